// File: rtl/ram_sdp_pkg.sv
// Shared types and byte-lane helpers for the byte-enable SDP RAM.
// Helpers operate on MaxDw-wide words; callers zero-extend and slice.
package ram_sdp_pkg;

  localparam int unsigned MaxDw    = 256;
  localparam int unsigned MaxBytes = MaxDw / 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Even parity: each bit makes its byte plus itself an even number of ones.
  function automatic logic [MaxBytes-1:0] byte_parity(input logic [MaxDw-1:0] data);
    logic [MaxBytes-1:0] par;
    for (int i = 0; i < MaxBytes; i++) begin
      par[i] = ^data[8*i +: 8];
    end
    return par;
  endfunction

  function automatic logic [MaxDw-1:0] be_merge(input logic [MaxDw-1:0]    old_word,
                                                input logic [MaxDw-1:0]    new_word,
                                                input logic [MaxBytes-1:0] be);
    logic [MaxDw-1:0] res;
    for (int i = 0; i < MaxBytes; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_sdp_bank.sv
// Bare storage array: bit-masked registered write, registered read that holds when idle.
module ram_sdp_bank #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wmask_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sdp_be_init.sv
// Byte-enable SDP RAM with post-reset clear sweep, write->read forwarding and read pipeline.
// Optional per-byte even parity when RAM_SDP_PARITY_EN is defined.
module ram_sdp_be_init
  import ram_sdp_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 32,
  parameter int unsigned           ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned           RD_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    init_done_o,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_en_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic                    rd_valid_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    wr_drop_o,
  output logic                    par_err_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
`ifdef RAM_SDP_PARITY_EN
  localparam int unsigned BW = DATA_WIDTH + NB;
`else
  localparam int unsigned BW = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] sweep_q;
  logic                  init_done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          if (sweep_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            sweep_q <= sweep_q + 1'b1;
          end
        end
        ST_RUN: init_done_q <= 1'b1;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  logic                  wr_en_q, rd_en_q, rd_oob_q, wr_drop_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [NB-1:0]         wr_be_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  wr_in_rng, rd_in_rng;

  assign wr_in_rng = {1'b0, wr_addr_i} < DepthW;
  assign rd_in_rng = {1'b0, rd_addr_i} < DepthW;

  // Zero-enable and out-of-range writes never reach the array or the forwarding path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      wr_en_q <= init_done_q & wr_en_i & wr_in_rng & (|wr_be_i);
      rd_en_q <= init_done_q & rd_en_i;
      if (!init_done_q && (wr_en_i || rd_en_i)) wr_drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    wr_addr_q <= wr_addr_i;
    wr_be_q   <= wr_be_i;
    wr_data_q <= wr_data_i;
    rd_addr_q <= rd_addr_i;
    rd_oob_q  <= ~rd_in_rng;
  end

  logic                  sweeping, bank_we, bank_re;
  logic [ADDR_WIDTH-1:0] bank_wa;
  logic [NB-1:0]         bank_be;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [BW-1:0]         bank_wd, bank_mask, bank_rd;
`ifdef RAM_SDP_PARITY_EN
  logic [MaxBytes-1:0]   wr_par_full;
  logic                  unused_wr_par;
  assign unused_wr_par = ^wr_par_full;
`endif

  always_comb begin
    sweeping   = (state_q == ST_INIT);
    bank_we    = sweeping | wr_en_q;
    bank_wa    = sweeping ? sweep_q : wr_addr_q;
    bank_be    = sweeping ? '1 : wr_be_q;
    bank_wdata = sweeping ? INIT_VALUE : wr_data_q;
    bank_mask  = '0;
    for (int i = 0; i < NB; i++) begin
      bank_mask[8*i +: 8] = {8{bank_be[i]}};
    end
`ifdef RAM_SDP_PARITY_EN
    wr_par_full = byte_parity(MaxDw'(bank_wdata));
    for (int i = 0; i < NB; i++) begin
      bank_mask[DATA_WIDTH+i] = bank_be[i];
    end
    bank_wd = {wr_par_full[NB-1:0], bank_wdata};
`else
    bank_wd = bank_wdata;
`endif
  end

  assign bank_re = rd_en_q & ~rd_oob_q;

  ram_sdp_bank #(
    .WIDTH      (BW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank (
    .clk_i   (clk_i),
    .we_i    (bank_we),
    .waddr_i (bank_wa),
    .wmask_i (bank_mask),
    .wdata_i (bank_wd),
    .re_i    (bank_re),
    .raddr_i (rd_addr_q),
    .rdata_o (bank_rd)
  );

  // The array read samples pre-write content, so same-cycle write bytes are merged afterwards.
  logic                  fwd_hit;
  logic                  v2_q, zero_q, oob2_q;
  logic [NB-1:0]         fwd_be_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  assign fwd_hit = wr_en_q & rd_en_q & ~rd_oob_q & (wr_addr_q == rd_addr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v2_q       <= 1'b0;
      zero_q     <= 1'b1;
      oob2_q     <= 1'b0;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else begin
      v2_q <= rd_en_q;
      if (rd_en_q) begin
        zero_q     <= 1'b0;
        oob2_q     <= rd_oob_q;
        fwd_be_q   <= fwd_hit ? wr_be_q : '0;
        fwd_data_q <= wr_data_q;
      end
    end
  end

  logic [MaxDw-1:0]      merged_full;
  logic                  unused_merged;
  logic [DATA_WIDTH-1:0] s2_data;
  logic                  s2_perr;
`ifdef RAM_SDP_PARITY_EN
  logic [MaxBytes-1:0]   rd_par_full;
  logic                  unused_rd_par;
  assign unused_rd_par = ^rd_par_full;
`endif

  always_comb begin
    merged_full = be_merge(MaxDw'(bank_rd[DATA_WIDTH-1:0]), MaxDw'(fwd_data_q),
                           MaxBytes'(fwd_be_q));
    if (zero_q)      s2_data = '0;
    else if (oob2_q) s2_data = INIT_VALUE;
    else             s2_data = merged_full[DATA_WIDTH-1:0];
`ifdef RAM_SDP_PARITY_EN
    rd_par_full = byte_parity(MaxDw'(bank_rd[DATA_WIDTH-1:0]));
    s2_perr = v2_q & ~oob2_q &
              (|((rd_par_full[NB-1:0] ^ bank_rd[BW-1:DATA_WIDTH]) & ~fwd_be_q));
`else
    s2_perr = 1'b0;
`endif
  end

  assign unused_merged = ^merged_full;

  if (RD_LATENCY <= 2) begin : g_lat2
    assign rd_valid_o = v2_q;
    assign rd_data_o  = s2_data;
    assign par_err_o  = s2_perr;
  end else begin : g_pipe
    localparam int unsigned Stages = RD_LATENCY - 2;
    logic                  pv_q [Stages];
    logic                  pe_q [Stages];
    logic [DATA_WIDTH-1:0] pd_q [Stages];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < Stages; i++) begin
          pv_q[i] <= 1'b0;
          pe_q[i] <= 1'b0;
          pd_q[i] <= '0;
        end
      end else begin
        pv_q[0] <= v2_q;
        pe_q[0] <= s2_perr;
        if (v2_q) pd_q[0] <= s2_data;
        for (int i = 1; i < Stages; i++) begin
          pv_q[i] <= pv_q[i-1];
          pe_q[i] <= pe_q[i-1];
          if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
        end
      end
    end

    assign rd_valid_o = pv_q[Stages-1];
    assign rd_data_o  = pd_q[Stages-1];
    assign par_err_o  = pe_q[Stages-1];
  end

  assign init_done_o = init_done_q;
  assign wr_drop_o   = wr_drop_q;

endmodule

// File: tb/tb_ram_sdp_be_init.sv
// Directed bench: three instances with RD_LATENCY 2/3/4 share one stimulus stream.
module tb_ram_sdp_be_init;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [31:0] exp;
  } vec_t;

  logic        clk, rst;
  logic        wr_en, rd_en;
  logic [4:0]  wr_addr, rd_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        idn [3];
  logic        rdv [3];
  logic [31:0] rdd [3];
  logic        wdr [3];
  logic        pe  [3];

  int   n_vec = 0;
  int   n_err = 0;
  vec_t q[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_sdp_be_init #(
      .DATA_WIDTH (32),
      .DEPTH      (32),
      .RD_LATENCY (g + 2)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .init_done_o (idn[g]),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_be_i     (wr_be),
      .wr_data_i   (wr_data),
      .rd_en_i     (rd_en),
      .rd_addr_i   (rd_addr),
      .rd_valid_o  (rdv[g]),
      .rd_data_o   (rdd[g]),
      .wr_drop_o   (wdr[g]),
      .par_err_o   (pe[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic push(input logic we, input logic [4:0] wa, input logic [3:0] be,
                      input logic [31:0] wd, input logic re, input logic [4:0] ra,
                      input logic [31:0] exp);
    vec_t v;
    v.we = we; v.wa = wa; v.be = be; v.wd = wd; v.re = re; v.ra = ra; v.exp = exp;
    q.push_back(v);
  endtask

  function automatic logic [31:0] pat(input logic [4:0] a);
    return {3'b000, a, 8'hC3, 3'b000, a, 8'h3C};
  endfunction

  // Applies one vector per cycle; instance d must answer a read issued at k after d+2 edges.
  task automatic run_q();
    int n;
    n = q.size();
    for (int t = 0; t < n + 5; t++) begin
      if (t < n) begin
        wr_en = q[t].we; wr_addr = q[t].wa; wr_be = q[t].be; wr_data = q[t].wd;
        rd_en = q[t].re; rd_addr = q[t].ra;
      end else begin
        idle();
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        int k;
        k = t + 1 - (d + 2);
        if (k >= 0 && k < n && q[k].re) begin
          check($sformatf("rd_valid_L%0d_t%0d", d + 2, t), 32'(rdv[d]), 32'd1);
          check($sformatf("rd_data_L%0d_a%0d", d + 2, q[k].ra), rdd[d], q[k].exp);
        end else begin
          check($sformatf("rd_idle_L%0d_t%0d", d + 2, t), 32'(rdv[d]), 32'd0);
        end
        check($sformatf("par_err_L%0d_t%0d", d + 2, t), 32'(pe[d]), 32'd0);
      end
    end
    q.delete();
  endtask

  task automatic sweep_and_check(input string tag);
    int vcount;
    vcount = 0;
    for (int c = 0; c < 32; c++) begin
      tick();
      for (int d = 0; d < 3; d++) vcount += int'(rdv[d]);
      if (c == 30) check({tag, "_init_early"}, 32'(idn[0]), 32'd0);
    end
    for (int d = 0; d < 3; d++) check({tag, "_init_done"}, 32'(idn[d]), 32'd1);
    check({tag, "_sweep_rd_valid"}, 32'(vcount), 32'd0);
  endtask

  initial begin
    int vcount;
    idle();
    rst = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      check("rst_init_done", 32'(idn[d]), 32'd0);
      check("rst_rd_valid", 32'(rdv[d]), 32'd0);
      check("rst_rd_data", rdd[d], 32'd0);
      check("rst_wr_drop", 32'(wdr[d]), 32'd0);
      check("rst_par_err", 32'(pe[d]), 32'd0);
    end
    rst = 1'b0;

    // Sweep with one dropped read+write request in the middle.
    vcount = 0;
    for (int c = 0; c < 32; c++) begin
      if (c == 10) begin
        wr_en = 1'b1; wr_addr = 5'd1; wr_be = 4'hF; wr_data = 32'hFFFF_FFFF;
        rd_en = 1'b1; rd_addr = 5'd1;
      end else begin
        idle();
      end
      tick();
      for (int d = 0; d < 3; d++) vcount += int'(rdv[d]);
      if (c == 30) check("init_early", 32'(idn[0]), 32'd0);
    end
    for (int d = 0; d < 3; d++) begin
      check("init_done", 32'(idn[d]), 32'd1);
      check("wr_drop_set", 32'(wdr[d]), 32'd1);
    end
    check("sweep_rd_valid", 32'(vcount), 32'd0);

    for (int a = 0; a < 32; a++) push(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'(a), 32'h0);
    run_q();

    // Byte-enable merge, same-cycle forwarding and zero-enable no-op.
    push(1'b1, 5'd5, 4'b1111, 32'hAABB_CCDD, 1'b0, 5'd0, 32'h0);
    push(1'b1, 5'd5, 4'b0101, 32'h1122_3344, 1'b0, 5'd0, 32'h0);
    push(1'b0, 5'd0, 4'b0000, 32'h0,         1'b1, 5'd5, 32'hAA22_CC44);
    push(1'b1, 5'd7, 4'b0011, 32'hDEAD_BEEF, 1'b1, 5'd7, 32'h0000_BEEF);
    push(1'b0, 5'd0, 4'b0000, 32'h0,         1'b1, 5'd7, 32'h0000_BEEF);
    push(1'b1, 5'd7, 4'b0000, 32'hFFFF_FFFF, 1'b1, 5'd7, 32'h0000_BEEF);
    push(1'b0, 5'd0, 4'b0000, 32'h0,         1'b1, 5'd7, 32'h0000_BEEF);
    run_q();

    for (int a = 8; a < 24; a++) push(1'b1, 5'(a), 4'hF, pat(5'(a)), 1'b0, 5'd0, 32'h0);
    run_q();
    for (int a = 8; a < 24; a++) push(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'(a), pat(5'(a)));
    push(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd31, 32'h0);
    push(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd0, 32'h0);
    run_q();

`ifdef RAM_SDP_PARITY_EN
    g_dut[0].u_dut.u_bank.mem_q[3][0] = ~g_dut[0].u_dut.u_bank.mem_q[3][0];
    rd_en = 1'b1; rd_addr = 5'd3;
    tick();
    rd_addr = 5'd4;
    tick();
    idle();
    check("par_bad_valid", 32'(rdv[0]), 32'd1);
    check("par_bad_err", 32'(pe[0]), 32'd1);
    tick();
    check("par_ok_valid", 32'(rdv[0]), 32'd1);
    check("par_ok_err", 32'(pe[0]), 32'd0);
    repeat (4) tick();
`endif

    // Reset in the middle of a read burst.
    for (int c = 0; c < 3; c++) begin
      rd_en = 1'b1; rd_addr = 5'(8 + c);
      tick();
    end
    rst = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      check("midrst_rd_valid", 32'(rdv[d]), 32'd0);
      check("midrst_wr_drop", 32'(wdr[d]), 32'd0);
      check("midrst_init_done", 32'(idn[d]), 32'd0);
    end
    rst = 1'b0;
    idle();
    sweep_and_check("resweep");
    for (int d = 0; d < 3; d++) check("resweep_wr_drop", 32'(wdr[d]), 32'd0);

    push(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd5, 32'h0);
    push(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd8, 32'h0);
    push(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7, 32'h0);
    run_q();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
